// File: rtl/instr_fetch_unit.sv
`default_nettype none
// instr_fetch_unit -- IF stage: PC, instruction-memory addressing and IF/ID register.
// Optional range check on fetch address enabled by defining IF_BOUNDS_CHECK_EN. Rev 1.0
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned MEM_WORDS  = 128,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_npc,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fetch_fault,
  output logic [15:0] fetch_count
);

`ifdef IF_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic [31:0] npc_q, npc_nxt;
  logic        valid_q, valid_nxt;
  logic        fault_q, fault_nxt;
  logic [15:0] count_q, count_nxt;
  logic [31:0] pc_inc;
  logic [15:0] count_inc;
  logic        out_of_range;

  assign pc_inc       = pc + 32'd1;
  assign count_inc    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
  // Constant-folds to zero when the range check is compiled out.
  assign out_of_range = BOUNDS_EN && (pc >= 32'(MEM_WORDS));

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr_q;
    npc_nxt   = npc_q;
    valid_nxt = valid_q;
    fault_nxt = fault_q;
    count_nxt = count_q;
    case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          pc_nxt    = branch_target;
          valid_nxt = 1'b0;
          instr_nxt = NOP_INSTR;
        end else if (stall) begin
          pc_nxt = pc;
        end else if (out_of_range) begin
          fault_nxt = 1'b1;
          valid_nxt = 1'b0;
          instr_nxt = NOP_INSTR;
          state_nxt = HALT;
        end else begin
          instr_nxt = mem_data;
          npc_nxt   = pc_inc;
          valid_nxt = 1'b1;
          count_nxt = count_inc;
          // A captured halt word parks the PC on itself.
          if (mem_data == HALT_INSTR) begin
            state_nxt = HALT;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      HALT: begin
        valid_nxt = 1'b0;
        instr_nxt = NOP_INSTR;
        if (branch_taken) begin
          pc_nxt    = branch_target;
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      instr_q <= NOP_INSTR;
      npc_q   <= 32'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      instr_q <= instr_nxt;
      npc_q   <= npc_nxt;
      valid_q <= valid_nxt;
      fault_q <= fault_nxt;
      count_q <= count_nxt;
    end
  end

  assign mem_addr    = pc;
  assign if_id_instr = instr_q;
  assign if_id_npc   = npc_q;
  assign if_id_valid = valid_q;
  assign halted      = (state == HALT);
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

endmodule
`default_nettype wire
